mext_seq_unit: RTL and testbench
================================

MEXT_SEQ_UNIT -- requirements
Module: mext_seq_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter EARLY_OUT, default 1; when 1, divide-by-zero and signed overflow complete without iterating.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port op  input  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports a, b  input  XLEN  rs1, rs2 operands; sampled only on the accepting edge.
REQ-008 SHALL have port kill  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  XLEN  selected result; held until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL move IDLE->CALC on start=1 and kill=0 (normal case), clearing the iteration counter.
REQ-014 SHALL move IDLE->DONE directly on acceptance when EARLY_OUT=1 and op is a divide/remainder with b=0, or with signed op, a=MIN and b=-1.
REQ-015 SHALL stay in CALC exactly XLEN cycles, one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes), then move to DONE.
REQ-016 SHALL assert done only in DONE, then return to IDLE on the next edge; done is high in cycle XLEN+1 after acceptance (cycle 1 for early-out).
REQ-017 SHALL ignore start while ready=0; operands are not re-sampled.
REQ-018 SHALL, on kill=1 in CALC or DONE, go to IDLE on the next edge with no done pulse and result unchanged; kill wins over a simultaneous start in IDLE.
REQ-019 SHALL compute MUL as the low XLEN bits; MULH, MULHSU and MULHU as the high XLEN bits of the 2*XLEN product, with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-020 SHALL compute DIV/REM as quotient truncated toward zero, with the remainder taking the dividend's sign; DIVU/REMU unsigned.
REQ-021 SHALL, for b=0, return quotient all-ones and remainder = a (both signed and unsigned).
REQ-022 SHALL, for signed a=MIN and b=-1, return quotient MIN and remainder 0.
REQ-023 SHALL produce identical results for REQ-021/022 with EARLY_OUT=0; only the latency differs (XLEN+1).
REQ-024 SHALL apply sign correction in the final CALC cycle so that result is registered on entry to DONE.

Reset
REQ-025 SHALL, on rst=1, asynchronously force state IDLE, ready=1, done=0, result=0, and clear the counter and datapath registers.
REQ-026 SHALL abandon an in-flight operation on reset without a done pulse; the first start after rst deasserts is accepted normally.

Structure
REQ-027 SHALL place op encodings, the FSM state typedef and counter-width function (clog2(XLEN+1)) in shared package mext_pkg.
REQ-028 SHALL instantiate one sub-module, mext_shift_core, holding the shared XLEN+1-bit adder and shift registers used by both multiply and divide; the FSM and sign logic stay in mext_seq_unit.

Verification (XLEN=32)
REQ-029 SHALL check: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33; MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-030 SHALL check: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-031 SHALL check: DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, done in cycle 1 (EARLY_OUT=1) and cycle 33 (EARLY_OUT=0).
REQ-032 SHALL check: kill asserted in CALC at cycle 10 -> no done, ready=1 next cycle, previous result retained; a new start is then accepted normally.
REQ-033 SHALL check: rst pulsed mid-CALC, asynchronously to clk -> ready=1 and result=0 immediately, no done; start held high during busy -> single done only.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared definitions for the sequential RV32/64 M-extension unit:
// funct3 op encodings, FSM state encoding and counter sizing.
package mext_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/mext_seq_unit_if.sv
// Request/response bundle between an issuing pipeline and mext_seq_unit.
interface mext_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, kill, input ready, done, result);
  modport slave  (input start, op, a, b, kill, output ready, done, result);
endinterface

// File: rtl/mext_shift_core.sv
// Radix-2 datapath on operand magnitudes: shift-add multiply and restoring
// divide sharing one XLEN+1-bit adder. acc_nxt/q_nxt are the post-step values.
module mext_shift_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   add_a, add_b, sum;
  logic            cin, cout;

  // Divide subtracts via add of the complement; carry-out means no borrow.
  always_comb begin
    shifted = {acc_q, q_q[XLEN-1]};
    if (is_div) begin
      add_a = shifted;
      add_b = ~{1'b0, m_q};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, acc_q};
      add_b = q_q[0] ? {1'b0, m_q} : '0;
      cin   = 1'b0;
    end
    {cout, sum} = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, cin};
    if (is_div) begin
      if (cout) begin
        acc_nxt = sum[XLEN-1:0];
        q_nxt   = {q_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[XLEN-1:0];
        q_nxt   = {q_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q_q[XLEN-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    m_d   = m_q;
    if (load) begin
      acc_d = '0;
      q_d   = a_mag;
      m_d   = b_mag;
    end else if (step) begin
      acc_d = acc_nxt;
      q_d   = q_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/mext_seq_unit.sv
// Sequential M-extension multiply/divide unit: FSM, operand sign handling,
// early-out for divide-by-zero/overflow, and result staging.
//   state   | meaning
//   IDLE    | ready for a request
//   CALC    | one radix-2 step per cycle, XLEN cycles
//   DONE    | done pulse, result presented
module mext_seq_unit
  import mext_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic           clk,
  input  logic           rst,
  mext_seq_unit_if.slave bus
);

  localparam int CNT_W = cnt_w(XLEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]  hold_q, hold_d;

  logic              is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, eo_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, eo_res;
  logic              load, step;
  logic [XLEN-1:0]   acc_nxt, q_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_val, div_fix, calc_res;

  always_comb begin
    is_div = bus.op[2];
    a_sgn  = is_div ? ~bus.op[0] : (bus.op != OP_MULHU);
    b_sgn  = is_div ? ~bus.op[0] : (bus.op == OP_MUL || bus.op == OP_MULH);
    a_neg  = a_sgn & bus.a[XLEN-1];
    b_neg  = b_sgn & bus.b[XLEN-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    eo_ovf = is_div & ~bus.op[0] & (&bus.b) &
             (bus.a == {1'b1, {(XLEN-1){1'b0}}});
    // Divide-by-zero: q = all ones, r = a.  Overflow: q = a (MIN), r = 0.
    if (b_zero) eo_res = bus.op[1] ? bus.a : '1;
    else        eo_res = bus.op[1] ? '0 : bus.a;
  end

  always_comb begin
    prod     = {acc_nxt, q_nxt};
    prod_fix = neg_q ? -prod : prod;
    div_val  = op_q[1] ? acc_nxt : q_nxt;
    div_fix  = neg_q ? -div_val : div_val;
    if (op_q[2])              calc_res = div_fix;
    else if (op_q == OP_MUL)  calc_res = prod_fix[XLEN-1:0];
    else                      calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  mext_shift_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .is_div  (op_q[2]),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d  = bus.op;
          cnt_d = '0;
          // Quotient of x/0 is all ones regardless of the dividend sign.
          if (is_div) neg_d = bus.op[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
          else        neg_d = a_neg ^ b_neg;
          if ((EARLY_OUT != 0) && is_div && (b_zero || eo_ovf)) begin
            pend_d  = eo_res;
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            pend_d  = calc_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!bus.kill) hold_d = pend_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      pend_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  // A kill in DONE suppresses the pulse and keeps the old result visible.
  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.done   = (state_q == ST_DONE) && !bus.kill;
  assign bus.result = bus.done ? pend_q : hold_q;

endmodule

// File: tb/tb_mext_seq_unit.sv
// Directed bench for mext_seq_unit: one instance with early-out, one without,
// driven by the same stimulus.
module tb_mext_seq_unit;
  import mext_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int checks = 0;
  int errors = 0;

  mext_seq_unit_if #(.XLEN(XLEN)) if0 ();
  mext_seq_unit_if #(.XLEN(XLEN)) if1 ();

  assign if0.start = start;
  assign if0.kill  = kill;
  assign if0.op    = op;
  assign if0.a     = a;
  assign if0.b     = b;
  assign if1.start = start;
  assign if1.kill  = kill;
  assign if1.op    = op;
  assign if1.a     = a;
  assign if1.b     = b;

  mext_seq_unit #(.XLEN(XLEN), .EARLY_OUT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mext_seq_unit #(.XLEN(XLEN), .EARLY_OUT(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic wait_ready();
    for (int i = 0; i < 100 && !(if0.ready && if1.ready); i++) @(negedge clk);
  endtask

  // Issues one request and records, per instance, the cycle of done
  // (accepting edge = cycle 1) and the result seen with it; -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat0, output int lat1,
                        output logic [31:0] r0, output logic [31:0] r1);
    lat0 = -1; lat1 = -1; r0 = '0; r1 = '0;
    @(negedge clk);
    wait_ready();
    op = o; a = va; b = vb; start = 1'b1;
    for (int c = 1; c <= 60 && (lat0 < 0 || lat1 < 0); c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (if0.done && lat0 < 0) begin lat0 = c; r0 = if0.result; end
      if (if1.done && lat1 < 0) begin lat1 = c; r1 = if1.result; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b want 1", if0.ready); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b want 0", if0.done); end
    checks++; if (if0.result !== 32'h0) begin errors++; $display("FAIL reset_result0 got %h want 0", if0.result); end
    checks++; if (if1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b want 1", if1.ready); end
    checks++; if (if1.result !== 32'h0) begin errors++; $display("FAIL reset_result1 got %h want 0", if1.result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    logic [31:0] va  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int l0, l1;
    logic [31:0] r0, r1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], l0, l1, r0, r1);
      checks++; if (r0 !== exp[i]) begin errors++; $display("FAIL mul%0d_result0 got %h want %h", i, r0, exp[i]); end
      checks++; if (r1 !== exp[i]) begin errors++; $display("FAIL mul%0d_result1 got %h want %h", i, r1, exp[i]); end
      checks++; if (l0 != 33) begin errors++; $display("FAIL mul%0d_latency0 got %0d want 33", i, l0); end
      checks++; if (l1 != 33) begin errors++; $display("FAIL mul%0d_latency1 got %0d want 33", i, l1); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] va  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int l0, l1;
    logic [31:0] r0, r1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], va[i], vb[i], l0, l1, r0, r1);
      checks++; if (r0 !== exp[i]) begin errors++; $display("FAIL div%0d_result0 got %h want %h", i, r0, exp[i]); end
      checks++; if (r1 !== exp[i]) begin errors++; $display("FAIL div%0d_result1 got %h want %h", i, r1, exp[i]); end
      checks++; if (l0 != 33) begin errors++; $display("FAIL div%0d_latency0 got %0d want 33", i, l0); end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [3] = '{OP_DIVU, OP_REM, OP_DIV};
    logic [31:0] va  [3] = '{32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] vb  [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    int l0, l1;
    logic [31:0] r0, r1;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], va[i], vb[i], l0, l1, r0, r1);
      checks++; if (r0 !== exp[i]) begin errors++; $display("FAIL special%0d_result_early got %h want %h", i, r0, exp[i]); end
      checks++; if (r1 !== exp[i]) begin errors++; $display("FAIL special%0d_result_full got %h want %h", i, r1, exp[i]); end
      checks++; if (l0 != 1) begin errors++; $display("FAIL special%0d_latency_early got %0d want 1", i, l0); end
      checks++; if (l1 != 33) begin errors++; $display("FAIL special%0d_latency_full got %0d want 33", i, l1); end
    end
  endtask

  task automatic test_kill();
    logic        seen;
    int          l0, l1;
    logic [31:0] r0, r1;
    @(negedge clk);
    wait_ready();
    // kill must win over a simultaneous start
    start = 1'b1; kill = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL kill_vs_start_ready got %b want 1", if0.ready); end
    kill = 1'b0;
    // start is still high here: the next edge accepts
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (if0.done || if1.done) seen = 1'b1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_early_done got %b want 0", seen); end
    checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL kill_ready0 got %b want 1", if0.ready); end
    checks++; if (if1.ready !== 1'b1) begin errors++; $display("FAIL kill_ready1 got %b want 1", if1.ready); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL kill_done0 got %b want 0", if0.done); end
    checks++; if (if0.result !== 32'h8000_0000) begin errors++; $display("FAIL kill_result0 got %h want 80000000", if0.result); end
    checks++; if (if1.result !== 32'h8000_0000) begin errors++; $display("FAIL kill_result1 got %h want 80000000", if1.result); end
    run_op(OP_DIVU, 32'd100, 32'd7, l0, l1, r0, r1);
    checks++; if (r0 !== 32'd14) begin errors++; $display("FAIL after_kill_result0 got %h want 0000000e", r0); end
    checks++; if (l0 != 33) begin errors++; $display("FAIL after_kill_latency0 got %0d want 33", l0); end
  endtask

  task automatic test_rst_busy();
    int          d0, d1;
    logic [31:0] r0, r1;
    @(negedge clk);
    wait_ready();
    op = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b want 1", if0.ready); end
    checks++; if (if0.result !== 32'h0) begin errors++; $display("FAIL rst_result0 got %h want 0", if0.result); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL rst_done0 got %b want 0", if0.done); end
    checks++; if (if1.result !== 32'h0) begin errors++; $display("FAIL rst_result1 got %h want 0", if1.result); end
    @(negedge clk);
    rst = 1'b0;
    // start held through busy; operands change but must not be re-sampled
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    d0 = 0; d1 = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a = 32'd1; b = 32'd1; end
      if (if0.done) begin d0++; r0 = if0.result; end
      if (if1.done) begin d1++; r1 = if1.result; end
      if (if0.done || if1.done) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (d0 != 1) begin errors++; $display("FAIL held_start_dones0 got %0d want 1", d0); end
    checks++; if (d1 != 1) begin errors++; $display("FAIL held_start_dones1 got %0d want 1", d1); end
    checks++; if (r0 !== 32'd14) begin errors++; $display("FAIL held_start_result0 got %h want 0000000e", r0); end
    checks++; if (r1 !== 32'd14) begin errors++; $display("FAIL held_start_result1 got %h want 0000000e", r1); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_kill();
    test_rst_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
